// File: rtl/irrigation_scheduler.sv
// Irrigation plant sequencer: arbitrates one pump between tank refill and soil
// watering, timing each phase from ticks derived from the slow divider outputs.

module irrigation_tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic tick
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Two-flop synchronizer followed by a previous-sample flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign tick = sync2_r & ~prev_r;

endmodule

module irrigation_scheduler #(
  parameter int unsigned SPRINKLER_TICKS = 4,
  parameter int unsigned DRIP_TICKS      = 6,
  parameter int unsigned FILL_TIMEOUT    = 60
) (
  input  logic       clk_896hz,
  input  logic       limpa,
  input  logic       sprinkler_clk,
  input  logic       drip_clk,
  input  logic       clk_1hz,
  input  logic       tank_low,
  input  logic       tank_full,
  input  logic       soil_dry,
  input  logic       sel_drip,
  output logic       valve_fill,
  output logic       valve_sprinkler,
  output logic       valve_drip,
  output logic       pump_on,
  output logic       fault,
  output logic       cycle_done,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    SPRINKLE = 3'd2,
    DRIP     = 3'd3,
    FAULT    = 3'd4
  } state_t;

  localparam logic [7:0] SPRINKLE_LAST = 8'(SPRINKLER_TICKS - 1);
  localparam logic [7:0] DRIP_LAST     = 8'(DRIP_TICKS - 1);
  localparam logic [7:0] FILL_LAST     = 8'(FILL_TIMEOUT - 1);

  state_t     state_r;
  state_t     state_s;
  logic [7:0] count_r;
  logic [7:0] count_s;
  logic [1:0] warm_r;
  logic       ticks_live_s;
  logic       sp_raw_s;
  logic       dr_raw_s;
  logic       hz_raw_s;
  logic       sp_tick_s;
  logic       dr_tick_s;
  logic       hz_tick_s;
  logic       phase_tick_s;
  logic [7:0] phase_last_s;
  logic       contra_s;
  logic       done_s;

  irrigation_tick_sync u_sync_sprinkler (
    .clk  (clk_896hz),
    .rst  (limpa),
    .din  (sprinkler_clk),
    .tick (sp_raw_s)
  );

  irrigation_tick_sync u_sync_drip (
    .clk  (clk_896hz),
    .rst  (limpa),
    .din  (drip_clk),
    .tick (dr_raw_s)
  );

  irrigation_tick_sync u_sync_1hz (
    .clk  (clk_896hz),
    .rst  (limpa),
    .din  (clk_1hz),
    .tick (hz_raw_s)
  );

  // Warm-up counter: hides a level already high at reset release from the edge detectors
  always_ff @(posedge clk_896hz) begin
    if (limpa) begin
      warm_r <= 2'd0;
    end else if (warm_r != 2'd3) begin
      warm_r <= warm_r + 2'd1;
    end else begin
      warm_r <= warm_r;
    end
  end

  assign ticks_live_s = (warm_r == 2'd3);
  assign sp_tick_s    = sp_raw_s & ticks_live_s;
  assign dr_tick_s    = dr_raw_s & ticks_live_s;
  assign hz_tick_s    = hz_raw_s & ticks_live_s;
  assign contra_s     = tank_low & tank_full;

  // State and shared phase counter registers
  always_ff @(posedge clk_896hz) begin
    if (limpa) begin
      state_r <= IDLE;
      count_r <= 8'd0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
    end
  end

  // Next-state, phase counter and completion pulse
  always_comb begin
    state_s      = state_r;
    count_s      = count_r;
    done_s       = 1'b0;
    phase_tick_s = 1'b0;
    phase_last_s = 8'd0;

    case (state_r)
      FILL: begin
        phase_tick_s = hz_tick_s;
        phase_last_s = FILL_LAST;
      end
      SPRINKLE: begin
        phase_tick_s = sp_tick_s;
        phase_last_s = SPRINKLE_LAST;
      end
      DRIP: begin
        phase_tick_s = dr_tick_s;
        phase_last_s = DRIP_LAST;
      end
      default: begin
        phase_tick_s = 1'b0;
        phase_last_s = 8'd0;
      end
    endcase

    case (state_r)
      IDLE: begin
        if (contra_s) begin
          state_s = FAULT;
        end else if (tank_low) begin
          state_s = FILL;
        end else if (soil_dry) begin
          state_s = sel_drip ? DRIP : SPRINKLE;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        // tank_full outranks a timeout tick arriving on the same edge
        if (contra_s) begin
          state_s = FAULT;
        end else if (tank_full) begin
          state_s = IDLE;
        end else if (phase_tick_s && (count_r == phase_last_s)) begin
          state_s = FAULT;
        end else begin
          state_s = FILL;
        end
      end
      SPRINKLE, DRIP: begin
        // Refill preempts watering; the abandoned cycle is not resumed
        if (contra_s) begin
          state_s = FAULT;
        end else if (tank_low) begin
          state_s = FILL;
        end else if (phase_tick_s && (count_r == phase_last_s)) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      FAULT: begin
        state_s = FAULT;
      end
      default: begin
        state_s = FAULT;
      end
    endcase

    if (state_s != state_r) begin
      count_s = 8'd0;
    end else if (phase_tick_s) begin
      count_s = count_r + 8'd1;
    end else begin
      count_s = count_r;
    end
  end

  // Registered outputs decoded from the next state so they move with the transition
  always_ff @(posedge clk_896hz) begin
    if (limpa) begin
      valve_fill      <= 1'b0;
      valve_sprinkler <= 1'b0;
      valve_drip      <= 1'b0;
      pump_on         <= 1'b0;
      fault           <= 1'b0;
      cycle_done      <= 1'b0;
      state_dbg       <= 3'd0;
    end else begin
      valve_fill      <= (state_s == FILL);
      valve_sprinkler <= (state_s == SPRINKLE);
      valve_drip      <= (state_s == DRIP);
      pump_on         <= (state_s == FILL) || (state_s == SPRINKLE) || (state_s == DRIP);
      fault           <= (state_s == FAULT);
      cycle_done      <= done_s;
      state_dbg       <= state_s;
    end
  end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Scoreboard bench for irrigation_scheduler: directed scenarios followed by
// randomized sensor and timebase activity, checked against a rule-level model.

module tb_irrigation_scheduler;

  localparam int SPR_N   = 4;
  localparam int DRIP_N  = 6;
  localparam int FILL_N  = 60;
  localparam int M_IDLE  = 0;
  localparam int M_FILL  = 1;
  localparam int M_SPR   = 2;
  localparam int M_DRIP  = 3;
  localparam int M_FAULT = 4;

  logic       clk;
  logic       limpa;
  logic       sprinkler_clk;
  logic       drip_clk;
  logic       clk_1hz;
  logic       tank_low;
  logic       tank_full;
  logic       soil_dry;
  logic       sel_drip;
  logic       valve_fill;
  logic       valve_sprinkler;
  logic       valve_drip;
  logic       pump_on;
  logic       fault;
  logic       cycle_done;
  logic [2:0] state_dbg;

  int vectors     = 0;
  int miscompares = 0;

  irrigation_scheduler dut (
    .clk_896hz       (clk),
    .limpa           (limpa),
    .sprinkler_clk   (sprinkler_clk),
    .drip_clk        (drip_clk),
    .clk_1hz         (clk_1hz),
    .tank_low        (tank_low),
    .tank_full       (tank_full),
    .soil_dry        (soil_dry),
    .sel_drip        (sel_drip),
    .valve_fill      (valve_fill),
    .valve_sprinkler (valve_sprinkler),
    .valve_drip      (valve_drip),
    .pump_on         (pump_on),
    .fault           (fault),
    .cycle_done      (cycle_done),
    .state_dbg       (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_state = M_IDLE;
  int         m_ticks = 0;
  bit         hist_sp[$];
  bit         hist_dr[$];
  bit         hist_hz[$];
  logic [8:0] exp_q[$];
  bit         t_sp, t_dr, t_hz, m_done;
  int         m_next;

  // A rising edge sampled two edges ago is acted on now; needs 3 samples since reset
  function automatic bit rose(input bit h[$]);
    if (h.size() < 3) return 1'b0;
    return h[h.size()-2] && !h[h.size()-3];
  endfunction

  function automatic logic [8:0] expect_vec(input int s, input bit d);
    logic vf, vs, vd;
    vf = (s == M_FILL);
    vs = (s == M_SPR);
    vd = (s == M_DRIP);
    return {vf, vs, vd, vf | vs | vd, logic'(s == M_FAULT), logic'(d), 3'(s)};
  endfunction

  always @(posedge clk) begin
    if (limpa) begin
      m_state = M_IDLE;
      m_ticks = 0;
      hist_sp.delete();
      hist_dr.delete();
      hist_hz.delete();
      exp_q.push_back(9'd0);
    end else begin
      t_sp = rose(hist_sp);
      t_dr = rose(hist_dr);
      t_hz = rose(hist_hz);
      hist_sp.push_back(sprinkler_clk);
      hist_dr.push_back(drip_clk);
      hist_hz.push_back(clk_1hz);
      if (hist_sp.size() > 3) void'(hist_sp.pop_front());
      if (hist_dr.size() > 3) void'(hist_dr.pop_front());
      if (hist_hz.size() > 3) void'(hist_hz.pop_front());
      m_next = m_state;
      m_done = 1'b0;
      if (m_state != M_FAULT && tank_low && tank_full) begin
        m_next = M_FAULT;
      end else if (m_state == M_IDLE) begin
        if (tank_low) m_next = M_FILL;
        else if (soil_dry) m_next = sel_drip ? M_DRIP : M_SPR;
      end else if (m_state == M_FILL) begin
        if (tank_full) m_next = M_IDLE;
        else if (t_hz) begin
          m_ticks++;
          if (m_ticks == FILL_N) m_next = M_FAULT;
        end
      end else if (m_state == M_SPR || m_state == M_DRIP) begin
        if (tank_low) m_next = M_FILL;
        else if ((m_state == M_SPR) ? t_sp : t_dr) begin
          m_ticks++;
          if (m_ticks == ((m_state == M_SPR) ? SPR_N : DRIP_N)) begin
            m_next = M_IDLE;
            m_done = 1'b1;
          end
        end
      end
      if (m_next != m_state) m_ticks = 0;
      m_state = m_next;
      exp_q.push_back(expect_vec(m_state, m_done));
    end
  end

  // ---------------- monitor ----------------
  logic [8:0] got;
  logic [8:0] want;

  always @(posedge clk) begin
    #1;
    got = {valve_fill, valve_sprinkler, valve_drip, pump_on, fault, cycle_done, state_dbg};
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard_empty t=%0t got=%b required=an expected entry", $time, got);
      miscompares++;
    end else begin
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        $display("FAIL outputs t=%0t got {vf,vs,vd,pump,fault,done,state}=%b required=%b",
                 $time, got, want);
        miscompares++;
      end
    end
    vectors++;
    assert ($onehot0({valve_fill, valve_sprinkler, valve_drip})) else begin
      $display("FAIL valve_exclusion t=%0t got=%b%b%b required=at most one high",
               $time, valve_fill, valve_sprinkler, valve_drip);
      miscompares++;
    end
  end

  // ---------------- stimulus ----------------
  int half_sp = 32, half_dr = 16, half_hz = 4;
  int ph_sp = 0, ph_dr = 0, ph_hz = 0;
  bit gen_sp = 0, gen_dr = 0, gen_hz = 0;
  bit rnd_mode = 0;

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (gen_sp) begin
        ph_sp++;
        if (ph_sp >= half_sp) begin ph_sp = 0; sprinkler_clk = ~sprinkler_clk; end
      end
      if (gen_dr) begin
        ph_dr++;
        if (ph_dr >= half_dr) begin ph_dr = 0; drip_clk = ~drip_clk; end
      end
      if (gen_hz) begin
        ph_hz++;
        if (ph_hz >= half_hz) begin ph_hz = 0; clk_1hz = ~clk_1hz; end
      end
      if (rnd_mode) begin
        if ($urandom_range(39, 0) == 0) tank_low = ~tank_low;
        if ($urandom_range(39, 0) == 0) tank_full = ~tank_full;
        if ($urandom_range(9, 0) == 0) soil_dry = ~soil_dry;
        if ($urandom_range(4, 0) == 0) sel_drip = ~sel_drip;
        limpa = ($urandom_range(299, 0) == 0);
      end
    end
  endtask

  task automatic do_reset();
    limpa = 1'b1;
    cycles(2);
    limpa = 1'b0;
  endtask

  initial begin
    limpa = 1'b1; sprinkler_clk = 1'b1; drip_clk = 1'b0; clk_1hz = 1'b0;
    tank_low = 1'b0; tank_full = 1'b0; soil_dry = 1'b1; sel_drip = 1'b0;
    // Reset with sprinkler_clk held high, then a sprinkler cycle at 64-cycle period
    cycles(2);
    limpa = 1'b0;
    ph_sp = 0; half_sp = 32; gen_sp = 1;
    cycles(100);
    soil_dry = 1'b0;
    cycles(220);
    gen_sp = 0;

    // Drip preempted by tank_low after 3 of 6 ticks, then refilled
    do_reset();
    sel_drip = 1'b1; drip_clk = 1'b0; ph_dr = 0; half_dr = 16; gen_dr = 1; soil_dry = 1'b1;
    cycles(90);
    tank_low = 1'b1;
    cycles(1);
    soil_dry = 1'b0;
    cycles(10);
    tank_low = 1'b0; tank_full = 1'b1;
    cycles(1);
    tank_full = 1'b0;
    cycles(4);
    gen_dr = 0;

    // tank_full on the same edge the 60th 1 Hz tick is acted on
    clk_1hz = 1'b0;
    cycles(4);
    tank_low = 1'b1;
    cycles(1);
    tank_low = 1'b0;
    for (int i = 0; i < FILL_N; i++) begin
      clk_1hz = 1'b1;
      if (i == FILL_N - 1) begin
        cycles(2);
        tank_full = 1'b1;
        cycles(2);
        clk_1hz = 1'b0;
        tank_full = 1'b0;
        cycles(4);
      end else begin
        cycles(4);
        clk_1hz = 1'b0;
        cycles(4);
      end
    end

    // Fill timeout into FAULT, held with tank_low high until reset
    tank_low = 1'b1; clk_1hz = 1'b0; ph_hz = 0; half_hz = 4; gen_hz = 1;
    cycles(520);
    cycles(40);
    do_reset();
    tank_low = 1'b0; gen_hz = 0;
    cycles(4);

    // Contradictory tank sensors in IDLE
    tank_low = 1'b1; tank_full = 1'b1;
    cycles(3);
    tank_low = 1'b0; tank_full = 1'b0;
    cycles(3);
    do_reset();

    // Randomized activity
    for (int seg = 0; seg < 40; seg++) begin
      half_sp = $urandom_range(12, 1);
      half_dr = $urandom_range(12, 1);
      half_hz = $urandom_range(12, 1);
      gen_sp = 1; gen_dr = 1; gen_hz = 1;
      rnd_mode = 1;
      cycles($urandom_range(150, 50));
    end
    rnd_mode = 0;
    limpa = 1'b0;
    do_reset();
    cycles(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
